// File: rtl/debounce_timer_arbiter.sv
// debounce_timer_arbiter
//   Debounces NUM_SW bouncy switches with a single shared stability timer.
//   Switches whose synchronized level differs from their debounced level
//   request the timer; requests are granted round-robin. A granted switch
//   must stay at its new level for DEBOUNCE_LIMIT cycles before it commits.
//   Each commit emits a one-cycle press or release pulse.
module debounce_timer_arbiter #(
    parameter int NUM_SW         = 4,
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int CNT_W          = 18,
    localparam int IDX_W         = $clog2(NUM_SW)
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic [NUM_SW-1:0] i_Bouncy,
    output logic [NUM_SW-1:0] o_Debounced,
    output logic              o_Press_Pulse,
    output logic              o_Release_Pulse,
    output logic [IDX_W-1:0]  o_Event_Idx,
    output logic              o_Busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TIMING = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_LIMIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_SW - 1);

    state_t            state;
    state_t            state_next;
    logic [NUM_SW-1:0] sync_meta;
    logic [NUM_SW-1:0] sync;
    logic [NUM_SW-1:0] req;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  search_grant;

    // A switch wants the timer whenever its synchronized level disagrees
    // with the level already committed for it.
    assign req = sync ^ o_Debounced;

    // Round-robin pick: first requester strictly after the previous grant, wrapping.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // up front so no path leaves it unassigned, which would infer a latch.
        int  cand;
        logic found;
        search_grant = last_grant;
        found        = 1'b0;
        for (int i = 1; i <= NUM_SW; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_SW) begin
                cand = cand - NUM_SW;
            end
            if (!found && req[cand]) begin
                search_grant = IDX_W'(cand);
                found        = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge i_Clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (i_Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: grant, time the granted input, then commit.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_next = TIMING;
                end
            end
            TIMING: begin
                if (!req[o_Event_Idx]) begin
                    state_next = IDLE;
                end else if (cnt == CNT_LAST) begin
                    state_next = COMMIT;
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode: the timer is owned in both TIMING and COMMIT.
    always_comb begin
        o_Busy = (state != IDLE);
    end

    // Datapath: synchronizer, timer, grant tracking and registered outputs.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            sync_meta       <= '0;
            sync            <= '0;
            o_Debounced     <= '0;
            o_Press_Pulse   <= 1'b0;
            o_Release_Pulse <= 1'b0;
            o_Event_Idx     <= '0;
            cnt             <= '0;
            last_grant      <= IDX_LAST;
        end else begin
            sync_meta       <= i_Bouncy;
            sync            <= sync_meta;
            o_Press_Pulse   <= 1'b0;
            o_Release_Pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        cnt         <= '0;
                        o_Event_Idx <= search_grant;
                    end
                end
                TIMING: begin
                    if (!req[o_Event_Idx]) begin
                        // A glitch forfeits the turn so others are not starved.
                        last_grant <= o_Event_Idx;
                    end else if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    o_Debounced[o_Event_Idx] <= sync[o_Event_Idx];
                    o_Press_Pulse            <= sync[o_Event_Idx];
                    o_Release_Pulse          <= !sync[o_Event_Idx];
                    last_grant               <= o_Event_Idx;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debounce_timer_arbiter.sv
// Self-checking bench for debounce_timer_arbiter with a transaction-level
// reference model: a switch holding the timer must survive DEBOUNCE_LIMIT
// consecutive sampled cycles after its grant cycle, then commits one cycle later.
module tb_debounce_timer_arbiter;

    localparam int NUM_SW = 4;
    localparam int LIMIT  = 4;
    localparam int CNT_W  = 3;

    logic       clk;
    logic       i_Reset;
    logic [3:0] i_Bouncy;
    logic [3:0] o_Debounced;
    logic       o_Press_Pulse;
    logic       o_Release_Pulse;
    logic [1:0] o_Event_Idx;
    logic       o_Busy;

    debounce_timer_arbiter #(
        .NUM_SW         (NUM_SW),
        .DEBOUNCE_LIMIT (LIMIT),
        .CNT_W          (CNT_W)
    ) dut (
        .i_Clk           (clk),
        .i_Reset         (i_Reset),
        .i_Bouncy        (i_Bouncy),
        .o_Debounced     (o_Debounced),
        .o_Press_Pulse   (o_Press_Pulse),
        .o_Release_Pulse (o_Release_Pulse),
        .o_Event_Idx     (o_Event_Idx),
        .o_Busy          (o_Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [3:0] m_s1, m_s2, m_deb;
    logic       m_press, m_rel;
    logic [1:0] m_idx;
    int         m_owner;    // switch holding the timer, -1 when free
    int         m_held;     // cycles the owner has survived since its grant
    int         m_last;

    logic [8:0] dut_vec;
    assign dut_vec = {o_Debounced, o_Press_Pulse, o_Release_Pulse, o_Event_Idx, o_Busy};

    function automatic logic [8:0] model_vec();
        return {m_deb, m_press, m_rel, m_idx, (m_owner >= 0)};
    endfunction

    // Advance the model by one clock edge using pre-edge values.
    task automatic model_edge(input logic [3:0] in, input logic rst);
        logic [3:0] want;
        bit         found;
        int         c;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            m_press = 1'b0; m_rel = 1'b0; m_idx = '0;
            m_owner = -1; m_held = 0; m_last = NUM_SW - 1;
            return;
        end
        want    = m_s2 ^ m_deb;
        m_press = 1'b0;
        m_rel   = 1'b0;
        if (m_owner < 0) begin
            found = 1'b0;
            for (int k = 1; k <= NUM_SW; k++) begin
                c = (m_last + k) % NUM_SW;
                if (!found && want[c]) begin
                    found   = 1'b1;
                    m_owner = c;
                end
            end
            if (found) begin
                m_held = 0;
                m_idx  = 2'(m_owner);
            end
        end else if (m_held < LIMIT) begin
            if (!want[m_owner]) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end else begin
            m_deb[m_owner] = m_s2[m_owner];
            m_press        = m_s2[m_owner];
            m_rel          = !m_s2[m_owner];
            m_last         = m_owner;
            m_owner        = -1;
        end
        m_s2 = m_s1;
        m_s1 = in;
    endtask

    // Drive one cycle of stimulus and move both DUT and model across the edge.
    task automatic step(input logic [3:0] in, input logic rst);
        i_Bouncy = in;
        i_Reset  = rst;
        model_edge(in, rst);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step(4'hF, 1'b1);
        step(4'hF, 1'b1);
        n_checks++;
        if (dut_vec !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h want=%h", dut_vec, 9'h000);
        end
        for (int k = 0; k < 3; k++) begin
            step(4'hF, 1'b0);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL reset_release k=%0d got=%h want=%h", k, dut_vec, model_vec());
            end
        end
        n_checks++;
        if (o_Event_Idx !== 2'd0 || o_Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL first_grant idx=%0d busy=%b want idx=0 busy=1", o_Event_Idx, o_Busy);
        end
    endtask

    task automatic test_single_press();
        step(4'h0, 1'b1);
        step(4'h0, 1'b1);
        for (int k = 0; k < 10; k++) begin
            step(4'h1, 1'b0);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL press_model k=%0d got=%h want=%h", k, dut_vec, model_vec());
            end
            n_checks++;
            if (o_Press_Pulse !== (k == 7) || o_Debounced !== ((k >= 7) ? 4'h1 : 4'h0)) begin
                n_fail++;
                $display("FAIL press_latency k=%0d press=%b deb=%h", k, o_Press_Pulse, o_Debounced);
            end
        end
        n_checks++;
        if (o_Event_Idx !== 2'd0) begin
            n_fail++;
            $display("FAIL press_idx got=%0d want=0", o_Event_Idx);
        end
    endtask

    task automatic test_abort();
        for (int k = 0; k < 12; k++) begin
            step((k < 2) ? 4'h3 : 4'h1, 1'b0);
            n_checks++;
            if (dut_vec !== model_vec() || o_Debounced[1] !== 1'b0 || o_Press_Pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL abort k=%0d got=%h want=%h", k, dut_vec, model_vec());
            end
        end
        for (int k = 0; k < 10; k++) begin
            step(4'h3, 1'b0);
            n_checks++;
            if (dut_vec !== model_vec() || o_Press_Pulse !== (k == 7)
                || o_Debounced !== ((k >= 7) ? 4'h3 : 4'h1)) begin
                n_fail++;
                $display("FAIL abort_recommit k=%0d got=%h want=%h", k, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        bit exp_press;
        step(4'h0, 1'b1);
        for (int k = 0; k < 30; k++) begin
            step(4'hF, 1'b0);
            exp_press = (k >= 7) && (k <= 25) && ((k - 7) % 6 == 0);
            n_checks++;
            if (dut_vec !== model_vec() || o_Press_Pulse !== exp_press
                || (exp_press && o_Event_Idx !== 2'((k - 7) / 6))) begin
                n_fail++;
                $display("FAIL b2b k=%0d got=%h want=%h press_want=%b", k, dut_vec, model_vec(), exp_press);
            end
        end
        // Last commit was idx 3, so the next search must wrap to idx 0.
        for (int k = 0; k < 3; k++) begin
            step(4'h0, 1'b0);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL wrap k=%0d got=%h want=%h", k, dut_vec, model_vec());
            end
        end
        n_checks++;
        if (o_Event_Idx !== 2'd0 || o_Busy !== 1'b1) begin
            n_fail++;
            $display("FAIL wrap_grant idx=%0d busy=%b want idx=0 busy=1", o_Event_Idx, o_Busy);
        end
        for (int k = 0; k < 10; k++) begin
            step(4'hF, 1'b0);
            n_checks++;
            if (dut_vec !== model_vec()) begin
                n_fail++;
                $display("FAIL wrap_settle k=%0d got=%h want=%h", k, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_release();
        for (int k = 0; k < 10; k++) begin
            step(4'hB, 1'b0);
            n_checks++;
            if (dut_vec !== model_vec() || o_Press_Pulse !== 1'b0 || o_Release_Pulse !== (k == 7)
                || o_Debounced !== ((k >= 7) ? 4'hB : 4'hF)) begin
                n_fail++;
                $display("FAIL release k=%0d got=%h want=%h", k, dut_vec, model_vec());
            end
        end
        n_checks++;
        if (o_Event_Idx !== 2'd2) begin
            n_fail++;
            $display("FAIL release_idx got=%0d want=2", o_Event_Idx);
        end
    endtask

    task automatic test_reset_mid();
        step(4'h0, 1'b1);
        for (int k = 0; k < 5; k++) step(4'h8, 1'b0);
        n_checks++;
        if (o_Busy !== 1'b1 || o_Event_Idx !== 2'd3) begin
            n_fail++;
            $display("FAIL mid_timing busy=%b idx=%0d want busy=1 idx=3", o_Busy, o_Event_Idx);
        end
        step(4'h8, 1'b1);
        n_checks++;
        if (dut_vec !== 9'h000) begin
            n_fail++;
            $display("FAIL mid_reset got=%h want=%h", dut_vec, 9'h000);
        end
        for (int k = 0; k < 10; k++) begin
            step(4'h8, 1'b0);
            n_checks++;
            if (dut_vec !== model_vec() || o_Press_Pulse !== (k == 7)
                || o_Debounced !== ((k >= 7) ? 4'h8 : 4'h0)) begin
                n_fail++;
                $display("FAIL mid_redebounce k=%0d got=%h want=%h", k, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] cur;
        logic       rst;
        int         commits;
        cur     = 4'h0;
        commits = 0;
        step(cur, 1'b1);
        for (int k = 0; k < 4000; k++) begin
            for (int b = 0; b < NUM_SW; b++) begin
                if ($urandom_range(0, 11) == 0) cur[b] = ~cur[b];
            end
            rst = ($urandom_range(0, 499) == 0);
            step(cur, rst);
            if (o_Press_Pulse || o_Release_Pulse) commits++;
            n_checks++;
            if (dut_vec !== model_vec() || (o_Press_Pulse && o_Release_Pulse)) begin
                n_fail++;
                $display("FAIL random k=%0d in=%h got=%h want=%h", k, cur, dut_vec, model_vec());
            end
        end
        n_checks++;
        if (commits == 0) begin
            n_fail++;
            $display("FAIL random_activity commits=%0d want>0", commits);
        end
    endtask

    initial begin
        i_Reset  = 1'b1;
        i_Bouncy = 4'h0;
        m_owner  = -1;
        m_held   = 0;
        m_last   = NUM_SW - 1;
        test_reset();
        test_single_press();
        test_abort();
        test_back_to_back();
        test_release();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
